// File: rtl/rom_port_arbiter.sv
// -----------------------------------------------------------------------------
// rom_port_arbiter
//
// Lets NUM_REQ requesters share the single read port of the password ROM,
// for example the login check, the password-change path and the RNG/challenge
// logic. Requests are served one at a time in round-robin order. The
// arbiter drives the ROM address and waits ROM_LAT cycles for the read. It
// then returns the captured word to the requester that won the grant.
//
// Compile-time option:
//   ROM_ARB_FIXED_PRIO_EN - when defined, the lowest-index requester always
//                           wins and the round-robin pointer is ignored.
//                           Timing is the same as the default build.
//
// Ports:
//   clock      in   system clock, all logic on posedge
//   rst        in   synchronous reset, active-high
//   req        in   [NUM_REQ]          per-requester read request level
//   req_addr   in   [NUM_REQ*ADDR_W]   requester i at [i*ADDR_W +: ADDR_W]
//   gnt        out  [NUM_REQ]          one-hot, one-cycle grant pulse
//   rsp_valid  out  [NUM_REQ]          one-hot, one-cycle response pulse
//   rsp_data   out  [DATA_W]           captured ROM word, held after the pulse
//   rom_addr   out  [ADDR_W]           registered ROM address
//   rom_data   in   [DATA_W]           ROM read data
//   owner      out  [clog2(NUM_REQ)]   current / last granted requester
//   busy       out  high while waiting for the ROM
// -----------------------------------------------------------------------------
module rom_port_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 16,
  parameter int ROM_LAT = 2
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                      busy
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = 3;
  localparam logic [CW-1:0]      LAT_LAST = CW'(ROM_LAT - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
  localparam logic [OW-1:0]      RR_RESET = OW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NUM_REQ-1:0]  r_gnt, w_gnt_nxt;
  logic [NUM_REQ-1:0]  r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0]   r_rsp_data, w_rsp_data_nxt;
  logic [ADDR_W-1:0]   r_rom_addr, w_rom_addr_nxt;
  logic [OW-1:0]       r_owner, w_owner_nxt;
  logic                r_busy, w_busy_nxt;
  logic [OW-1:0]       r_rr_ptr, w_rr_ptr_nxt;
  logic [CW-1:0]       r_lat_cnt, w_lat_cnt_nxt;

  logic                w_found;
  logic [OW-1:0]       w_win;
  logic [OW-1:0]       w_idx;

  // Winner selection among the currently asserted requests.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
`ifdef ROM_ARB_FIXED_PRIO_EN
    // Scan downward so the lowest set index is the last one written.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = OW'(k);
      if (req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end else begin
        w_found = w_found;
      end
    end
`else
    // Search starts just after the last winner, so that winner ends up last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = OW'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end else begin
        w_found = w_found;
      end
    end
`endif
  end

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = '0;
    w_rsp_valid_nxt = '0;
    w_rsp_data_nxt  = r_rsp_data;
    w_rom_addr_nxt  = r_rom_addr;
    w_owner_nxt     = r_owner;
    w_busy_nxt      = r_busy;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_lat_cnt_nxt   = r_lat_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_gnt_nxt      = ONE_HOT0 << w_win;
          w_rom_addr_nxt = req_addr[w_win*ADDR_W +: ADDR_W];
          w_owner_nxt    = w_win;
`ifdef ROM_ARB_FIXED_PRIO_EN
          w_rr_ptr_nxt   = r_rr_ptr;
`else
          w_rr_ptr_nxt   = w_win;
`endif
          w_lat_cnt_nxt  = '0;
          w_busy_nxt     = 1'b1;
          w_state_nxt    = S_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        w_lat_cnt_nxt = r_lat_cnt + 3'd1;
        if (r_lat_cnt == LAT_LAST) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_RESP: begin
        // rom_addr has been stable for ROM_LAT cycles, so rom_data is valid now.
        w_rsp_data_nxt  = rom_data;
        w_rsp_valid_nxt = ONE_HOT0 << r_owner;
        w_busy_nxt      = 1'b0;
        w_state_nxt     = S_IDLE;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight read.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rom_addr  <= '0;
      r_owner     <= '0;
      r_busy      <= 1'b0;
      r_rr_ptr    <= RR_RESET;
      r_lat_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rom_addr  <= w_rom_addr_nxt;
      r_owner     <= w_owner_nxt;
      r_busy      <= w_busy_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_lat_cnt   <= w_lat_cnt_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rom_addr  = r_rom_addr;
  assign owner     = r_owner;
  assign busy      = r_busy;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rom_port_arbiter
//
// Self-checking bench for rom_port_arbiter at its default parameters. A
// small ROM with ROM_LAT cycles of delay feeds the DUT. A transaction-level
// reference model runs every cycle. It records when each grant happens and
// when its response is due, then checks every DUT output against those
// cycle numbers. A vector table and hand-written sequences add fixed
// expectations on top. The ROM_ARB_FIXED_PRIO_EN build is also followed.
// -----------------------------------------------------------------------------
module tb_rom_port_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 16;
  localparam int ROM_LAT = 2;

  logic                      clock;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic [ADDR_W-1:0]         rom_addr;
  logic [DATA_W-1:0]         rom_data;
  logic [1:0]                owner;
  logic                      busy;

  rom_port_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .ROM_LAT (ROM_LAT)
  ) dut (
    .clock     (clock),
    .rst       (rst),
    .req       (req),
    .req_addr  (req_addr),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .owner     (owner),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ROM contents and a read pipeline ROM_LAT cycles deep.
  logic [DATA_W-1:0] rom [8];
  logic [DATA_W-1:0] rom_pipe [ROM_LAT];

  always_ff @(posedge clock) begin
    rom_pipe[0] <= rom[rom_addr];
    for (int k = 1; k < ROM_LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
  end
  assign rom_data = rom_pipe[ROM_LAT-1];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: grant and response timestamps plus the last-granted info.
  int                cyc_n     = 0;
  int                m_free    = 0;
  int                m_gnt_cyc = -100;
  int                m_rsp_cyc = -1;
  int                m_rr      = NUM_REQ - 1;
  int                m_owner   = 0;
  logic [ADDR_W-1:0] m_addr    = '0;
  logic [DATA_W-1:0] m_word    = '0;
  logic [DATA_W-1:0] m_data    = '0;

  function automatic int pick(input logic [NUM_REQ-1:0] r, input int rr);
    int i;
`ifdef ROM_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NUM_REQ; k++) if (r[k]) return k;
`else
    for (int k = 1; k <= NUM_REQ; k++) begin
      i = (rr + k) % NUM_REQ;
      if (r[i]) return i;
    end
`endif
    return -1;
  endfunction

  // Advance one clock cycle: update the model from this cycle's inputs, then check.
  task automatic cyc();
    int w;
    logic [NUM_REQ-1:0] exp_g;
    logic [NUM_REQ-1:0] exp_r;
    if (rst) begin
      m_gnt_cyc = -100;
      m_rsp_cyc = -1;
      m_addr    = '0;
      m_owner   = 0;
      m_data    = '0;
      m_rr      = NUM_REQ - 1;
      m_free    = cyc_n + 1;
    end else if (cyc_n >= m_free && req != '0) begin
      w         = pick(req, m_rr);
      m_owner   = w;
      m_addr    = req_addr[w*ADDR_W +: ADDR_W];
      m_rr      = w;
      m_word    = rom[m_addr];
      m_gnt_cyc = cyc_n + 1;
      m_rsp_cyc = cyc_n + ROM_LAT + 2;
      m_free    = cyc_n + ROM_LAT + 2;
    end
    @(posedge clock);
    #1;
    cyc_n++;
    if (cyc_n == m_rsp_cyc) m_data = m_word;
    exp_g = (cyc_n == m_gnt_cyc) ? (NUM_REQ'(1) << m_owner) : '0;
    exp_r = (cyc_n == m_rsp_cyc) ? (NUM_REQ'(1) << m_owner) : '0;
    chk("mdl_gnt", 32'(gnt), 32'(exp_g));
    chk("mdl_rsp_valid", 32'(rsp_valid), 32'(exp_r));
    chk("mdl_rsp_data", 32'(rsp_data), 32'(m_data));
    chk("mdl_rom_addr", 32'(rom_addr), 32'(m_addr));
    chk("mdl_owner", 32'(owner), 32'(m_owner));
    chk("mdl_busy", 32'(busy), 32'((cyc_n >= m_gnt_cyc) && (cyc_n < m_rsp_cyc)));
  endtask

  typedef struct {
    logic [NUM_REQ-1:0] req;
    logic [ADDR_W-1:0]  a0;
    logic [ADDR_W-1:0]  a1;
    logic [ADDR_W-1:0]  a2;
    logic [NUM_REQ-1:0] gnt;
    logic [DATA_W-1:0]  data;
  } vec_t;

  vec_t vt [8];
  int   g_cyc [$];
  int   g_idx [$];
  int   exp_order [6];
  int   n_g1;
  int   n_g2;

  initial begin
    rom[0] = 16'h1234; rom[1] = 16'hBEEF; rom[2] = 16'h0F0F; rom[3] = 16'hC0DE;
    rom[4] = 16'h7E57; rom[5] = 16'hA5C3; rom[6] = 16'h5A5A; rom[7] = 16'hFACE;

    // Vectors applied in sequence from idle; the round-robin pointer carries over.
    vt[0] = '{3'b010, 3'd0, 3'd5, 3'd0, 3'b010, 16'hA5C3};
`ifdef ROM_ARB_FIXED_PRIO_EN
    vt[1] = '{3'b111, 3'd1, 3'd2, 3'd3, 3'b001, 16'hBEEF};
`else
    vt[1] = '{3'b111, 3'd1, 3'd2, 3'd3, 3'b100, 16'hC0DE};
`endif
    vt[2] = '{3'b011, 3'd4, 3'd6, 3'd0, 3'b001, 16'h7E57};
`ifdef ROM_ARB_FIXED_PRIO_EN
    vt[3] = '{3'b101, 3'd0, 3'd0, 3'd6, 3'b001, 16'h1234};
`else
    vt[3] = '{3'b101, 3'd0, 3'd0, 3'd6, 3'b100, 16'h5A5A};
`endif
    vt[4] = '{3'b110, 3'd0, 3'd1, 3'd2, 3'b010, 16'hBEEF};
    vt[5] = '{3'b001, 3'd7, 3'd0, 3'd0, 3'b001, 16'hFACE};
    vt[6] = '{3'b001, 3'd2, 3'd0, 3'd0, 3'b001, 16'h0F0F};
    vt[7] = '{3'b100, 3'd0, 3'd0, 3'd7, 3'b100, 16'hFACE};

    // Reset then idle.
    rst = 1'b1; req = '0; req_addr = '0;
    cyc(); cyc();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cyc();

    // Vector table: grant at t, response at t+ROM_LAT+1.
    for (int i = 0; i < 8; i++) begin
      req = vt[i].req;
      req_addr = {vt[i].a2, vt[i].a1, vt[i].a0};
      cyc();
      chk("tbl_gnt", 32'(gnt), 32'(vt[i].gnt));
      req = '0;
      req_addr = 9'($urandom);
      for (int k = 0; k < ROM_LAT + 1; k++) cyc();
      chk("tbl_rsp_valid", 32'(rsp_valid), 32'(vt[i].gnt));
      chk("tbl_rsp_data", 32'(rsp_data), 32'(vt[i].data));
    end

    // All requests held: grant order and spacing.
    rst = 1'b1; cyc(); rst = 1'b0;
    req = 3'b111; req_addr = 9'($urandom);
    for (int i = 0; i < 24; i++) begin
      cyc();
      for (int k = 0; k < NUM_REQ; k++) begin
        if (gnt[k]) begin g_cyc.push_back(cyc_n); g_idx.push_back(k); end
      end
    end
    req = '0;
    for (int i = 0; i < 4; i++) cyc();
`ifdef ROM_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 0, 1, 2};
`endif
    chk("rr_grant_count", 32'(g_idx.size()), 32'd6);
    for (int i = 0; i < 6 && i < g_idx.size(); i++) begin
      chk("rr_order", 32'(g_idx[i]), 32'(exp_order[i]));
      if (i > 0) chk("rr_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'(ROM_LAT + 2));
    end

    // Late arrival of req[2] during the transaction of requester 0.
    req = 3'b001; req_addr = 9'($urandom);
    cyc();
    chk("late_gnt0", 32'(gnt), 32'b001);
    req = 3'b100;
    cyc(); chk("late_no_gnt_a", 32'(gnt), 32'd0);
    cyc(); chk("late_no_gnt_b", 32'(gnt), 32'd0);
    cyc(); chk("late_no_gnt_c", 32'(gnt), 32'd0);
    chk("late_rsp0", 32'(rsp_valid), 32'b001);
    cyc(); chk("late_gnt2", 32'(gnt), 32'b100);
    req = '0;
    for (int i = 0; i < 4; i++) cyc();

    // Reset during WAIT discards the read.
    req = 3'b001; req_addr = 9'($urandom);
    cyc();
    chk("midrst_gnt", 32'(gnt), 32'b001);
    req = '0;
    cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    req = 3'b011;
    cyc();
    chk("midrst_regrant", 32'(gnt), 32'b001);
    req = '0;
    for (int i = 0; i < 4; i++) cyc();

`ifdef ROM_ARB_FIXED_PRIO_EN
    // Fixed priority: requester 1 starves requester 2 until it drops.
    n_g1 = 0; n_g2 = 0;
    req = 3'b110;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (gnt[1]) n_g1++;
      if (gnt[2]) n_g2++;
    end
    chk("fp_gnt1_count", 32'(n_g1), 32'd4);
    chk("fp_gnt2_never", 32'(n_g2), 32'd0);
    req = 3'b100;
    n_g2 = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (gnt[2]) n_g2++;
    end
    chk("fp_gnt2_after_drop", 32'(n_g2 > 0), 32'd1);
    req = '0;
    for (int i = 0; i < 4; i++) cyc();
`endif

    // Random traffic with occasional resets, checked by the model each cycle.
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      req = ($urandom_range(0, 3) == 0) ? '0 : 3'($urandom);
      req_addr = 9'($urandom);
      cyc();
    end
    rst = 1'b0; req = '0;
    for (int i = 0; i < 6; i++) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
